// File: rtl/rom_bus_responder.sv
// SRAM responder for SNES and MCU requests. SNES strobes are edge-detected and
// latched, then served with timed SRAM read/write cycles; MCU accesses fill idle time.
module rom_bus_responder #(
    parameter int unsigned RD_CYCLES = 4,
    parameter int unsigned WR_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SNES_RD_N,
    input  logic        SNES_WR_N,
    input  logic [23:0] SNES_ADDR_DEC,
    input  logic        ROM_HIT,
    input  logic        IS_WRITABLE,
    input  logic [7:0]  SNES_DIN,
    output logic [7:0]  SNES_DOUT,
    output logic        SNES_DOE,
    input  logic        MCU_RRQ,
    input  logic        MCU_WRQ,
    input  logic [23:0] MCU_ADDR,
    input  logic [7:0]  MCU_DOUT,
    output logic [7:0]  MCU_DIN,
    output logic        MCU_RDY,
    output logic [23:0] RAM_ADDR,
    output logic [7:0]  RAM_DO,
    input  logic [7:0]  RAM_DI,
    output logic        RAM_OE_N,
    output logic        RAM_WE_N,
    output logic        RAM_DRIVE
);
    localparam int unsigned MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_SRD, S_SWR, S_MRD, S_MWR} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_rd_n_q, r_wr_n_q;
    logic               r_sp, r_sp_wr, r_sp_hit, r_sp_wrable;
    logic [23:0]        r_sp_addr;
    logic [7:0]         r_sp_data;
    logic               r_rd_hit;
    logic               r_mp, r_mp_wr;
    logic [23:0]        r_mp_addr;
    logic [7:0]         r_mp_data;
    logic [23:0]        r_ram_addr;
    logic [7:0]         r_ram_do;
    logic               r_ram_oe_n, r_ram_we_n, r_ram_drive;
    logic [7:0]         r_snes_dout, r_mcu_din;
    logic               r_snes_doe, r_mcu_rdy;

    logic               w_rd_evt, w_wr_evt, w_snes_evt, w_rd_hit_nxt;
    logic               w_mcu_req, w_mp_nxt, w_mp_avail;
    logic [CNT_W-1:0]   w_cnt_inc;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [23:0]        w_addr_nxt;
    logic [7:0]         w_do_nxt, w_dout_nxt, w_din_nxt;
    logic               w_oe_n_nxt, w_we_n_nxt, w_drive_nxt;
    logic               w_dispatch, w_sp_take, w_mp_done;

    assign w_rd_evt     = r_rd_n_q & ~SNES_RD_N;
    assign w_wr_evt     = ~r_wr_n_q & SNES_WR_N;
    assign w_snes_evt   = w_rd_evt | w_wr_evt;
    assign w_rd_hit_nxt = w_rd_evt ? ROM_HIT : r_rd_hit;
    assign w_mcu_req    = ~r_mp & (MCU_RRQ | MCU_WRQ);
    assign w_mp_nxt     = w_mp_done ? 1'b0 : (r_mp | w_mcu_req);
    assign w_mp_avail   = r_mp & (r_state != S_MRD) & (r_state != S_MWR);
    assign w_cnt_inc    = r_cnt + CNT_W'(1);

    // Strobe edge detect, request capture and the one-deep pending slots
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_n_q    <= 1'b1;
            r_wr_n_q    <= 1'b1;
            r_sp        <= 1'b0;
            r_sp_wr     <= 1'b0;
            r_sp_hit    <= 1'b0;
            r_sp_wrable <= 1'b0;
            r_sp_addr   <= '0;
            r_sp_data   <= '0;
            r_rd_hit    <= 1'b0;
            r_snes_doe  <= 1'b0;
            r_mp        <= 1'b0;
            r_mp_wr     <= 1'b0;
            r_mp_addr   <= '0;
            r_mp_data   <= '0;
            r_mcu_rdy   <= 1'b1;
        end else begin
            r_rd_n_q <= SNES_RD_N;
            r_wr_n_q <= SNES_WR_N;
            // A newer SNES event replaces an unserved one
            if (w_snes_evt) begin
                r_sp        <= 1'b1;
                r_sp_wr     <= ~w_rd_evt;
                r_sp_hit    <= ROM_HIT;
                r_sp_wrable <= IS_WRITABLE;
                r_sp_addr   <= SNES_ADDR_DEC;
                r_sp_data   <= SNES_DIN;
            end else if (w_sp_take) begin
                r_sp <= 1'b0;
            end
            r_rd_hit   <= w_rd_hit_nxt;
            r_snes_doe <= ~SNES_RD_N & w_rd_hit_nxt;
            r_mp       <= w_mp_nxt;
            if (w_mcu_req) begin
                r_mp_wr   <= MCU_WRQ;
                r_mp_addr <= MCU_ADDR;
                r_mp_data <= MCU_DOUT;
            end
            r_mcu_rdy <= ~w_mp_nxt;
        end
    end

    // Next state and next SRAM/output values; dispatch picks SNES before MCU
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_ram_addr;
        w_do_nxt    = r_ram_do;
        w_oe_n_nxt  = 1'b1;
        w_we_n_nxt  = 1'b1;
        w_drive_nxt = 1'b0;
        w_dout_nxt  = r_snes_dout;
        w_din_nxt   = r_mcu_din;
        w_dispatch  = 1'b0;
        w_sp_take   = 1'b0;
        w_mp_done   = 1'b0;

        case (r_state)
            S_IDLE: w_dispatch = 1'b1;
            S_SRD, S_MRD: begin
                if (r_cnt == RD_LAST) begin
                    if (r_state == S_SRD) begin
                        w_dout_nxt = RAM_DI;
                    end else begin
                        w_din_nxt = RAM_DI;
                        w_mp_done = 1'b1;
                    end
                    w_dispatch = 1'b1;
                end else begin
                    w_cnt_nxt  = w_cnt_inc;
                    w_oe_n_nxt = 1'b0;
                end
            end
            S_SWR, S_MWR: begin
                if (r_cnt == WR_LAST) begin
                    w_mp_done  = (r_state == S_MWR);
                    w_dispatch = 1'b1;
                end else begin
                    // WE rises for the final count so data is held past the strobe
                    w_cnt_nxt   = w_cnt_inc;
                    w_drive_nxt = 1'b1;
                    w_we_n_nxt  = (w_cnt_inc == WR_LAST);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_dispatch) begin
            w_sp_take   = r_sp;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
            if (r_sp) begin
                if (!r_sp_wr && r_sp_hit) begin
                    w_state_nxt = S_SRD;
                    w_addr_nxt  = r_sp_addr;
                    w_oe_n_nxt  = 1'b0;
                end else if (r_sp_wr && r_sp_hit && r_sp_wrable) begin
                    w_state_nxt = S_SWR;
                    w_addr_nxt  = r_sp_addr;
                    w_do_nxt    = r_sp_data;
                    w_we_n_nxt  = 1'b0;
                    w_drive_nxt = 1'b1;
                end
            end else if (w_mp_avail) begin
                w_addr_nxt = r_mp_addr;
                if (r_mp_wr) begin
                    w_state_nxt = S_MWR;
                    w_do_nxt    = r_mp_data;
                    w_we_n_nxt  = 1'b0;
                    w_drive_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_MRD;
                    w_oe_n_nxt  = 1'b0;
                end
            end
        end
    end

    // State register and registered SRAM / read-data outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ram_addr  <= '0;
            r_ram_do    <= '0;
            r_ram_oe_n  <= 1'b1;
            r_ram_we_n  <= 1'b1;
            r_ram_drive <= 1'b0;
            r_snes_dout <= '0;
            r_mcu_din   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ram_addr  <= w_addr_nxt;
            r_ram_do    <= w_do_nxt;
            r_ram_oe_n  <= w_oe_n_nxt;
            r_ram_we_n  <= w_we_n_nxt;
            r_ram_drive <= w_drive_nxt;
            r_snes_dout <= w_dout_nxt;
            r_mcu_din   <= w_din_nxt;
        end
    end

    assign SNES_DOUT = r_snes_dout;
    assign SNES_DOE  = r_snes_doe;
    assign MCU_DIN   = r_mcu_din;
    assign MCU_RDY   = r_mcu_rdy;
    assign RAM_ADDR  = r_ram_addr;
    assign RAM_DO    = r_ram_do;
    assign RAM_OE_N  = r_ram_oe_n;
    assign RAM_WE_N  = r_ram_we_n;
    assign RAM_DRIVE = r_ram_drive;

endmodule
